// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory and
// produces the registered F->D bundle (InstrD/PCD/PCPlus4D/ValidD).
module fetch_stage #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     StallF,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [DATA_WIDTH-1:0]    NOP  = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);

  // Handshake: a request is outstanding whenever imem_req=1; imem_addr must not
  // change until imem_ack=1 arrives in the same cycle as imem_rdata.
  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] tgt_q, tgt_d;
  logic [DATA_WIDTH-1:0]    skid_q, skid_d;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pcd_q, pcd_d;
  logic [ADDRESS_WIDTH-1:0] pcp4_q, pcp4_d;
  logic                     valid_q, valid_d;
  logic                     load;
  logic [DATA_WIDTH-1:0]    load_data;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;

  assign pc_plus4  = pc_q + FOUR;
  assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem_addr = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    skid_d    = skid_q;
    load      = 1'b0;
    load_data = imem_rdata;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          if (PCSrcE) begin
            pc_d = PCTargetE;
          end else if (StallF) begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            load = 1'b1;
            pc_d = pc_plus4;
          end
        end else if (PCSrcE) begin
          tgt_d   = PCTargetE;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        // The stale request must complete before the redirect target is issued.
        if (PCSrcE) tgt_d = PCTargetE;
        if (imem_ack) begin
          pc_d    = PCSrcE ? PCTargetE : tgt_q;
          state_d = ST_REQ;
        end
      end
      default: begin
        if (PCSrcE) begin
          skid_d  = '0;
          pc_d    = PCTargetE;
          state_d = ST_REQ;
        end else if (!StallF) begin
          load      = 1'b1;
          load_data = skid_q;
          pc_d      = pc_plus4;
          state_d   = ST_REQ;
        end
      end
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD || PCSrcE) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (StallF) begin
      valid_d = valid_q;
    end else if (load) begin
      instr_d = load_data;
      pcd_d   = pc_q;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      skid_q  <= '0;
      instr_q <= NOP;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      skid_q  <= skid_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Pipelined instruction-fetch stage that sits directly upstream of the F->D boundary and feeds the decode stage (control unit, register file, sign extend). It owns the PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency. It produces the registered D-stage bundle InstrD/PCD/PCPlus4D/ValidD. Stall, flush and branch/jump redirects from later stages are honoured without losing or duplicating instructions.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction-memory address
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDRESS_WIDTH  fetch address; equals the internal pc
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  DATA_WIDTH  fetched instruction, valid when imem_ack=1
StallF  input  1  hazard stall; freezes fetch progress and the D registers
FlushD  input  1  squash the D-stage instruction (turn it into a bubble)
PCSrcE  input  1  taken branch/jump resolved in E
PCTargetE  input  ADDRESS_WIDTH  redirect target, valid when PCSrcE=1
InstrD  output  DATA_WIDTH  registered instruction to decode
PCD  output  ADDRESS_WIDTH  PC of InstrD
PCPlus4D  output  ADDRESS_WIDTH  PCD+4
ValidD  output  1  InstrD is a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=IDLE, imem_req=0.
  - InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, ValidD=0.
  - Skid and redirect registers cleared.
- States:
  - IDLE: imem_req=0. Always goes to REQ on the next cycle.
  - REQ: imem_req=1, imem_addr=pc.
    - ack & PCSrcE: discard rdata; pc<=PCTargetE; stay REQ.
    - ack & StallF: rdata->skid register; go HOLD.
    - ack, no stall, no redirect: D load (see below); pc<=pc+4; stay REQ.
    - no ack & PCSrcE: tgt<=PCTargetE; go DROP.
    - no ack otherwise: stay REQ.
  - DROP: imem_req=1 and imem_addr stays at the old pc until ack (the address never changes while a request is outstanding).
    - A new PCSrcE overwrites tgt.
    - On ack: discard rdata; pc<=tgt (or PCTargetE if PCSrcE is high the same cycle); go REQ.
  - HOLD: imem_req=0.
    - PCSrcE: drop skid; pc<=PCTargetE; go REQ.
    - else if StallF=0: D loaded from skid; pc<=pc+4; go REQ.
- D registers, priority high to low:
  - rst.
  - FlushD or PCSrcE: InstrD=NOP, ValidD=0; PCD/PCPlus4D don't care, held.
  - StallF: hold all four.
  - Load: InstrD=rdata or skid, PCD=pc, PCPlus4D=pc+4, ValidD=1.
  - Otherwise (no instruction available): bubble, ValidD=0, InstrD=NOP.
- Latency: an instruction acked in cycle N appears on InstrD in cycle N+1 (unstalled). With a 0-wait memory (ack every REQ cycle), throughput is 1 instruction/cycle.
- Arithmetic: pc+4 is modulo 2^ADDRESS_WIDTH and wraps. PCTargetE is taken verbatim; bits [1:0] are not checked.
- Ordering: no instruction is ever issued twice to D or skipped, except by redirect/flush.
- Simultaneous events: FlushD with StallF means flush wins. PCSrcE with StallF means the redirect wins. imem_ack is ignored in IDLE and HOLD.

Test Plan:
- Reset: rst pulse mid-run with RESET_PC=0 -> same cycle InstrD=0x00000013, ValidD=0, imem_req=0; the first cycle after release is IDLE; REQ with imem_addr=0 follows.
- Streaming: ack every cycle, rdata=addr^0xA5 -> PCD = 0,4,8,12 on consecutive cycles, ValidD=1, PCPlus4D=PCD+4.
- Wait states: ack 2 cycles after each req -> imem_addr held stable; ValidD=0 on the non-ack cycles; no duplicated PCD.
- Stall: StallF=1 for 3 cycles with ack arriving during the stall -> D holds; HOLD reached, imem_req=0; on release the skid instruction appears with the next PC, and no instruction is lost.
- Redirect in flight: req to 0x10 outstanding, PCSrcE=1 with PCTargetE=0x40 -> imem_addr stays 0x10 until ack; that data is discarded; next req is 0x40; ValidD=0 during the redirect.
- Wrap and flush: pc=0xFFFFFFFC with ack -> PCPlus4D=0, next addr 0. FlushD=1 with StallF=1 -> ValidD=0, InstrD=NOP.
